// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the width helper used to size the iteration counter.
package divisor_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/subtrator_borrow_look_ahead_param.sv
// Combinational N-bit subtractor (a - b) with a generate/propagate
// borrow look-ahead network; borrow=1 means a < b.
module subtrator_borrow_look_ahead_param #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   bc;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign g[i]    = ~a[i] & b[i];
        assign p[i]    = ~(a[i] ^ b[i]);
        assign diff[i] = a[i] ^ b[i] ^ bc[i];
    end

    // Each borrow is the flattened sum of products of g/p below it, so no
    // borrow depends on the previous borrow signal.
    always_comb begin
        logic t;
        bc = '0;
        t  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int k = j + 1; k < i; k++)
                    t = t & p[k];
                bc[i] = bc[i] | t;
            end
        end
    end

    assign borrow = bc[N];

endmodule

// File: rtl/divisor_sequencial_param.sv
// Sequential N-bit unsigned restoring divider, one quotient bit per clock,
// behind a start/ready/done handshake. Optional DIVISOR_ZERO_CHECK_EN
// short-circuits a zero divisor straight to DONE with div_zero set.
module divisor_sequencial_param
    import divisor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_zero
);

    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

    logic [1:0]    state;
    logic [N-1:0]  q;
    logic [N-1:0]  divisor;
    logic [N:0]    rem;
    logic [CW-1:0] count;

    logic [N:0]    trial;
    logic [N:0]    diff;
    logic [N:0]    rem_next;
    logic [N-1:0]  q_next;
    logic          borrow;

    // The restoring invariant keeps rem < divisor, so its top bit stays clear.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[N];

    assign trial = {rem[N-1:0], q[N-1]};

    subtrator_borrow_look_ahead_param #(.N(N + 1)) u_sub (
        .a      (trial),
        .b      ({1'b0, divisor}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign rem_next = borrow ? trial : diff;
    assign q_next   = {q[N-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            div_zero <= 1'b0;
            Q        <= '0;
            R        <= '0;
            q        <= '0;
            divisor  <= '0;
            rem      <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ready   <= 1'b0;
                        q       <= A;
                        divisor <= B;
                        rem     <= '0;
                        count   <= '0;
`ifdef DIVISOR_ZERO_CHECK_EN
                        if (B == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            Q        <= '1;
                            R        <= A;
                            div_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        Q        <= q_next;
                        R        <= rem_next[N-1:0];
                        div_zero <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
